data_mem_port: RTL and testbench

Parametrised single-port data memory with a valid/ready request channel and a held response channel, successor to the plain asynchronous word memory used by the single-cycle datapath. Reads return registered data after a configurable latency, and accesses outside the array are flagged with an error instead of aliasing. Optional per-byte write strobes support the multi-cycle and pipelined cores, which need `sb`/`sh` and a stallable memory stage.

---
 rtl/data_mem_port.sv | 157 +++++++++++++++
 tb/tb_data_mem_port.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_port.sv
// data_mem_port: single-port word memory behind a valid/ready request channel
// and a held response channel. One transaction is in flight at a time; the
// response appears a fixed LATENCY cycles after the request is accepted.
//
// Build option: define DATA_MEM_BYTE_EN to honour req_be on writes. Without
// it req_be is ignored and every in-range write replaces the whole word.
//
// DEPTH must be a power of two and at least 2. LATENCY must be in 1..4.

module data_mem_port #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = 2;

   // Wait-state preload: the WAIT state spends LATENCY-2 extra cycles
   // counting down before moving to RESP.
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [DATA_W-1:0] rspData_q;
   logic [DATA_W-1:0] rspData_d;
   logic              rspErr_q;
   logic              rspErr_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wordIdx;
   logic [IDX_W-1:0]  memIdx;
   logic              inRange;
   logic              accept;
   logic              memWrite;
   logic [DATA_W-1:0] memWord;

   // Address decode: drop the byte offset, then any bit above the array
   // index means the access falls outside the memory and must not alias.
   always_comb begin
      wordIdx = req_addr >> OFF_W;
      memIdx  = wordIdx[IDX_W-1:0];
      inRange = ((wordIdx >> IDX_W) == '0);
      memWord = mem[memIdx];
   end

   // Handshake decode; both outputs come straight from the state register.
   always_comb begin
      req_ready = (state_q == S_IDLE);
      rsp_valid = (state_q == S_RESP);
      rsp_rdata = rspData_q;
      rsp_err   = rspErr_q;
      accept    = req_valid && (state_q == S_IDLE);
      memWrite  = accept && req_write && inRange;
   end

`ifdef DATA_MEM_BYTE_EN
   // Writes commit on the acceptance edge, one byte lane per enable bit.
   always_ff @(posedge clk) begin
      if (memWrite) begin
         for (int b = 0; b < BYTES; b++) begin
            if (req_be[b]) begin
               mem[memIdx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end
`else
   logic unusedBe;
   assign unusedBe = ^req_be;

   // Writes commit on the acceptance edge and replace the full word.
   always_ff @(posedge clk) begin
      if (memWrite) begin
         mem[memIdx] <= req_wdata;
      end
   end
`endif

   // Next-state logic: capture the response at acceptance, count out the
   // latency, then hold the response until the consumer takes it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rspData_d = rspData_q;
      rspErr_d  = rspErr_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               rspData_d = (!req_write && inRange) ? memWord : '0;
               rspErr_d  = !inRange;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and response registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rspData_q <= '0;
         rspErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rspData_q <= rspData_d;
         rspErr_q  <= rspErr_d;
      end
   end

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed test of data_mem_port. Three instances run side
// by side with LATENCY 2, 1 and 4 (index 0, 1, 2); they share clock and reset.

module tb_data_mem_port;

   logic clk;
   logic rst_n;

   logic        reqValid [3];
   logic        reqWrite [3];
   logic [31:0] reqAddr  [3];
   logic [31:0] reqWdata [3];
   logic [3:0]  reqBe    [3];
   logic        rspReady [3];

   wire  [2:0]  reqReady;
   wire  [2:0]  rspValid;
   wire  [2:0]  rspErr;
   wire  [31:0] rspRdata [3];

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] bsExpected;

   // One instance per latency under test.
   for (genvar g = 0; g < 3; g++) begin : gDut
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      data_mem_port #(
         .DATA_W (32),
         .DEPTH  (1024),
         .ADDR_W (32),
         .LATENCY(LAT)
      ) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .req_valid(reqValid[g]),
         .req_ready(reqReady[g]),
         .req_write(reqWrite[g]),
         .req_addr (reqAddr[g]),
         .req_wdata(reqWdata[g]),
         .req_be   (reqBe[g]),
         .rsp_valid(rspValid[g]),
         .rsp_ready(rspReady[g]),
         .rsp_rdata(rspRdata[g]),
         .rsp_err  (rspErr[g])
      );
   end

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Present one request and leave the channel idle with scrambled inputs.
   task automatic applyStimulus(input int k, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
      @(negedge clk);
      reqValid[k] = 1'b1;
      reqWrite[k] = wr;
      reqAddr[k]  = addr;
      reqWdata[k] = wdata;
      reqBe[k]    = be;
      rspReady[k] = 1'b0;
      @(posedge clk);
      #1;
      reqValid[k] = 1'b0;
      reqWrite[k] = ~wr;
      reqAddr[k]  = 32'h0000_0004;
      reqWdata[k] = 32'h0BAD_0BAD;
      reqBe[k]    = 4'hF;
   endtask

   // Full transaction: accept, measure latency, hold in RESP, then release.
   task automatic runTxn(input string tag, input int k, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold,
                         input logic [31:0] expData, input logic expErr,
                         input int expLat);
      int          lat;
      logic [31:0] data;
      logic        err;
      logic        stableOk;
      lat = 0;
      checkOutput({tag, ".readyBefore"}, {31'd0, reqReady[k]}, 32'd1);
      applyStimulus(k, wr, addr, wdata, be);
      for (int c = 1; c <= 20; c++) begin
         if (rspValid[k]) begin
            lat = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput({tag, ".latency"}, lat, expLat);
      data     = rspRdata[k];
      err      = rspErr[k];
      stableOk = 1'b1;
      checkOutput({tag, ".rdata"}, data, expData);
      checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, expErr});
      for (int c = 0; c < hold; c++) begin
         @(posedge clk);
         #1;
         if (rspValid[k] !== 1'b1 || rspRdata[k] !== data ||
             rspErr[k] !== err || reqReady[k] !== 1'b0)
            stableOk = 1'b0;
      end
      if (hold > 0)
         checkOutput({tag, ".heldStable"}, {31'd0, stableOk}, 32'd1);
      rspReady[k] = 1'b1;
      @(posedge clk);
      #1;
      rspReady[k] = 1'b0;
      checkOutput({tag, ".readyAfter"}, {30'd0, reqReady[k], rspValid[k]}, 32'd2);
   endtask

   // Drop reset briefly between clock edges.
   task automatic pulseReset();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   initial begin
      logic sawValid;
      for (int k = 0; k < 3; k++) begin
         reqValid[k] = 1'b0;
         reqWrite[k] = 1'b0;
         reqAddr[k]  = '0;
         reqWdata[k] = '0;
         reqBe[k]    = '0;
         rspReady[k] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.ready",    {31'd0, reqReady[0]}, 32'd1);
      checkOutput("reset.valid",    {31'd0, rspValid[0]}, 32'd0);
      checkOutput("reset.rdata",    rspRdata[0], 32'd0);
      checkOutput("reset.err",      {31'd0, rspErr[0]}, 32'd0);
      checkOutput("reset.readyAll", {29'd0, reqReady}, 32'd7);
      checkOutput("reset.validAll", {29'd0, rspValid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle.valid", {31'd0, rspValid[0]}, 32'd0);

      // Full-word write then read back.
      runTxn("wr10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 2);
      runTxn("rd10", 0, 1'b0, 32'h10, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0, 2);
      // Byte offset bits are ignored.
      runTxn("rd13", 0, 1'b0, 32'h13, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0, 2);

      // Byte strobes.
`ifdef DATA_MEM_BYTE_EN
      bsExpected = 32'h11BB33DD;
`else
      bsExpected = 32'hAABBCCDD;
`endif
      runTxn("wr20a", 0, 1'b1, 32'h20, 32'h11223344, 4'hF,    0, 32'h0, 1'b0, 2);
      runTxn("wr20b", 0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 1'b0, 2);
      runTxn("rd20",  0, 1'b0, 32'h20, 32'h0,        4'h0,    0, bsExpected, 1'b0, 2);

      // Out of range: flagged, no aliasing onto word 0.
      runTxn("wr0",    0, 1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0, 2);
      runTxn("rdOor",  0, 1'b0, 32'h1000, 32'h0,        4'h0, 0, 32'h0, 1'b1, 2);
      runTxn("wrOor",  0, 1'b1, 32'h1000, 32'h5,        4'hF, 0, 32'h0, 1'b1, 2);
      runTxn("rd0",    0, 1'b0, 32'h0,    32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0, 2);
      runTxn("rdLast", 0, 1'b0, 32'hFFC,  32'h0,        4'h0, 0, 32'h0, 1'b0, 2);

      // Backpressure and latency sweep.
      runTxn("bp.l2", 0, 1'b0, 32'h10, 32'h0,        4'h0, 5, 32'hDEADBEEF, 1'b0, 2);
      runTxn("wr.l1", 1, 1'b1, 32'h8,  32'h0F0F0F0F, 4'hF, 5, 32'h0, 1'b0, 1);
      runTxn("rd.l1", 1, 1'b0, 32'h8,  32'h0,        4'h0, 5, 32'h0F0F0F0F, 1'b0, 1);
      runTxn("wr.l4", 2, 1'b1, 32'h10, 32'h5A5AA5A5, 4'hF, 5, 32'h0, 1'b0, 4);
      runTxn("rd.l4", 2, 1'b0, 32'h10, 32'h0,        4'h0, 5, 32'h5A5AA5A5, 1'b0, 4);

      // Reset during WAIT discards the pending read.
      applyStimulus(2, 1'b0, 32'h10, 32'h0, 4'h0);
      pulseReset();
      sawValid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (rspValid[2]) sawValid = 1'b1;
      end
      checkOutput("rstRead.noRsp", {31'd0, sawValid}, 32'd0);
      checkOutput("rstRead.ready", {31'd0, reqReady[2]}, 32'd1);

      // A write accepted before reset stays committed.
      applyStimulus(2, 1'b1, 32'h40, 32'h12345678, 4'hF);
      pulseReset();
      @(posedge clk);
      #1;
      checkOutput("rstWrite.ready", {31'd0, reqReady[2]}, 32'd1);
      runTxn("rstWrite.rd", 2, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
